// File: rtl/biu_mem_arbiter_pkg.sv
// biu_mem_arbiter_pkg
// Shared encodings for the BIU memory-port arbiter: FSM states and the
// owner/last-grant master identifiers.
package biu_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_HOLD = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_OWN_IFU = 1'b0,
    ARB_OWN_LSU = 1'b1
  } arb_own_e;

endpackage

// File: rtl/biu_rr_pick2.sv
// biu_rr_pick2
// Combinational 2-way round-robin picker.
//   req[0] = IFU request, req[1] = LSU request
//   last   = master granted most recently
//   gnt    = one-hot grant (0 when nobody requests)
module biu_rr_pick2
  import biu_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  arb_own_e   last,
  output logic [1:0] gnt
);

  // On a conflict the master that did not win last time goes first.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == ARB_OWN_LSU) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/biu_mem_arbiter.sv
// biu_mem_arbiter
// Shares the single memory port between the IFU and the LSU. One transaction
// is outstanding at a time; the response is steered back to the issuing master
// without buffering.
//   clk, rst           : clock, synchronous active-high reset
//   ifu_req_* / rsp_*  : IFU fetch request (read only) and response channel
//   lsu_req_* / rsp_*  : LSU load/store request and response channel
//   mem_req_* / rsp_*  : memory-side request and response channel
module biu_mem_arbiter
  import biu_mem_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ifu_req_valid,
  output logic            ifu_req_ready,
  input  logic [AW-1:0]   ifu_req_addr,
  output logic            ifu_rsp_valid,
  input  logic            ifu_rsp_ready,
  output logic [DW-1:0]   ifu_rsp_rdata,
  output logic            ifu_rsp_err,
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic [AW-1:0]   lsu_req_addr,
  input  logic            lsu_req_write,
  input  logic [DW-1:0]   lsu_req_wdata,
  input  logic [DW/8-1:0] lsu_req_wstrb,
  output logic            lsu_rsp_valid,
  input  logic            lsu_rsp_ready,
  output logic [DW-1:0]   lsu_rsp_rdata,
  output logic            lsu_rsp_err,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_req_addr,
  output logic            mem_req_write,
  output logic [DW-1:0]   mem_req_wdata,
  output logic [DW/8-1:0] mem_req_wstrb,
  input  logic            mem_rsp_valid,
  output logic            mem_rsp_ready,
  input  logic [DW-1:0]   mem_rsp_rdata,
  input  logic            mem_rsp_err
);

  arb_state_e state_q, state_d;
  arb_own_e   owner_q, owner_d;
  arb_own_e   last_q,  last_d;
  arb_own_e   win;
  logic       req_vld;
  logic       own_rsp_rdy;
  logic [1:0] gnt;

  biu_rr_pick2 u_pick (
    .req  ({lsu_req_valid, ifu_req_valid}),
    .last (last_q),
    .gnt  (gnt)
  );

  // State, owner and last-grant registers; last_grant resets to LSU so the
  // IFU wins the first conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= ARB_OWN_IFU;
      last_q  <= ARB_OWN_LSU;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic and the request/response steering muxes.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    win           = owner_q;
    req_vld       = 1'b0;
    own_rsp_rdy   = 1'b0;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_rsp_rdata = {DW{1'b0}};
    ifu_rsp_err   = 1'b0;
    lsu_rsp_valid = 1'b0;
    lsu_rsp_rdata = {DW{1'b0}};
    lsu_rsp_err   = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = {AW{1'b0}};
    mem_req_write = 1'b0;
    mem_req_wdata = {DW{1'b0}};
    mem_req_wstrb = {(DW/8){1'b0}};
    mem_rsp_ready = 1'b0;

    case (state_q)
      ARB_IDLE, ARB_HOLD: begin
        // IDLE picks a fresh winner; HOLD keeps the latched owner so a late
        // request from the other master cannot preempt it.
        if (state_q == ARB_IDLE) begin
          win = gnt[1] ? ARB_OWN_LSU : ARB_OWN_IFU;
        end else begin
          win = owner_q;
        end
        req_vld = (win == ARB_OWN_LSU) ? lsu_req_valid : ifu_req_valid;
        if (req_vld) begin
          mem_req_valid = 1'b1;
          owner_d       = win;
          if (win == ARB_OWN_LSU) begin
            mem_req_addr  = lsu_req_addr;
            mem_req_write = lsu_req_write;
            mem_req_wdata = lsu_req_wdata;
            mem_req_wstrb = lsu_req_wstrb;
            lsu_req_ready = mem_req_ready;
          end else begin
            mem_req_addr  = ifu_req_addr;
            ifu_req_ready = mem_req_ready;
          end
          if (mem_req_ready) begin
            state_d = ARB_WAIT;
            last_d  = win;
          end else begin
            state_d = ARB_HOLD;
          end
        end else begin
          // A dropped request in HOLD is abandoned without issuing anything.
          state_d = ARB_IDLE;
        end
      end
      ARB_WAIT: begin
        own_rsp_rdy   = (owner_q == ARB_OWN_LSU) ? lsu_rsp_ready : ifu_rsp_ready;
        mem_rsp_ready = own_rsp_rdy;
        if (owner_q == ARB_OWN_LSU) begin
          lsu_rsp_valid = mem_rsp_valid;
          lsu_rsp_rdata = mem_rsp_valid ? mem_rsp_rdata : {DW{1'b0}};
          lsu_rsp_err   = mem_rsp_valid & mem_rsp_err;
        end else begin
          ifu_rsp_valid = mem_rsp_valid;
          ifu_rsp_rdata = mem_rsp_valid ? mem_rsp_rdata : {DW{1'b0}};
          ifu_rsp_err   = mem_rsp_valid & mem_rsp_err;
        end
        // Returning to IDLE costs one turnaround cycle before the next grant.
        if (mem_rsp_valid && own_rsp_rdy) begin
          state_d = ARB_IDLE;
        end else begin
          state_d = ARB_WAIT;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_biu_mem_arbiter.sv
// tb_biu_mem_arbiter
// Directed scenarios with a scoreboard: every expected memory transaction is
// queued when its request is driven, checked at the memory request handshake
// and popped when its response is delivered to the owning master.
module tb_biu_mem_arbiter;

  typedef struct {
    logic        lsu;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
  logic [31:0] ifu_req_addr, ifu_rsp_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_write, lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_err;
  logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_rdata;
  logic [3:0]  lsu_req_wstrb;
  logic        mem_req_valid, mem_req_ready, mem_req_write, mem_rsp_valid, mem_rsp_ready, mem_rsp_err;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_rdata;
  logic [3:0]  mem_req_wstrb;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  biu_mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
    .ifu_rsp_rdata(ifu_rsp_rdata), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_write(lsu_req_write), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready),
    .lsu_rsp_rdata(lsu_rsp_rdata), .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_write(mem_req_write), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
    .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic lsu, input logic [31:0] addr, input logic wr,
                      input logic [31:0] wdata, input logic [3:0] wstrb,
                      input logic [31:0] rdata, input logic err);
    exp_t e;
    e.lsu = lsu; e.addr = addr; e.wr = wr; e.wdata = wdata;
    e.wstrb = wstrb; e.rdata = rdata; e.err = err;
    exp_q.push_back(e);
  endtask

  // Request side against the head of the scoreboard (no pop).
  task automatic chk_req();
    exp_t e;
    #1;
    if (exp_q.size() == 0) begin
      check_eq("sb_empty_req", 64'd1, 64'd0);
      return;
    end
    e = exp_q[0];
    check_eq("req_valid", mem_req_valid, 1'b1);
    check_eq("req_addr", mem_req_addr, e.addr);
    check_eq("req_write", mem_req_write, e.wr);
    check_eq("req_wdata", mem_req_wdata, e.wdata);
    check_eq("req_wstrb", mem_req_wstrb, e.wstrb);
    check_eq("ifu_req_ready", ifu_req_ready, !e.lsu && mem_req_ready);
    check_eq("lsu_req_ready", lsu_req_ready, e.lsu && mem_req_ready);
  endtask

  // Drive one memory response beat for the head entry; pop on handshake.
  task automatic rsp_beat();
    exp_t e;
    logic own_rdy;
    if (exp_q.size() == 0) begin
      check_eq("sb_empty_rsp", 64'd1, 64'd0);
      return;
    end
    e = exp_q[0];
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = e.rdata;
    mem_rsp_err   = e.err;
    #1;
    own_rdy = e.lsu ? lsu_rsp_ready : ifu_rsp_ready;
    check_eq("ifu_rsp_valid", ifu_rsp_valid, !e.lsu);
    check_eq("lsu_rsp_valid", lsu_rsp_valid, e.lsu);
    check_eq("rsp_rdata", e.lsu ? lsu_rsp_rdata : ifu_rsp_rdata, e.rdata);
    check_eq("rsp_err", e.lsu ? lsu_rsp_err : ifu_rsp_err, e.err);
    check_eq("other_rdata", e.lsu ? ifu_rsp_rdata : lsu_rsp_rdata, 32'd0);
    check_eq("mem_rsp_ready", mem_rsp_ready, own_rdy);
    check_eq("wait_req_valid", mem_req_valid, 1'b0);
    check_eq("wait_ifu_rdy", ifu_req_ready, 1'b0);
    check_eq("wait_lsu_rdy", lsu_req_ready, 1'b0);
    if (own_rdy) void'(exp_q.pop_front());
  endtask

  task automatic chk_quiet(input string tag);
    check_eq({tag, "_valids"},
             {mem_req_valid, ifu_rsp_valid, lsu_rsp_valid}, 3'b000);
    check_eq({tag, "_readies"},
             {ifu_req_ready, lsu_req_ready, mem_rsp_ready}, 3'b000);
    check_eq({tag, "_data"},
             {mem_req_addr, ifu_rsp_rdata}, 64'd0);
  endtask

  task automatic clear_inputs();
    ifu_req_valid = 1'b0; ifu_req_addr = 32'd0; ifu_rsp_ready = 1'b0;
    lsu_req_valid = 1'b0; lsu_req_addr = 32'd0; lsu_req_write = 1'b0;
    lsu_req_wdata = 32'd0; lsu_req_wstrb = 4'd0; lsu_rsp_ready = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'd0; mem_rsp_err = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    #1 chk_quiet("reset");
    rst = 1'b0;
  endtask

  // Both masters request together; IFU must win, LSU gets the grant two
  // cycles later.
  task automatic conflict_pair(input logic [31:0] ia, input logic [31:0] la,
                               input logic [31:0] ird, input logic [31:0] lrd);
    tick();
    ifu_req_valid = 1'b1; ifu_req_addr = ia;
    lsu_req_valid = 1'b1; lsu_req_addr = la; lsu_req_write = 1'b0;
    lsu_req_wdata = 32'h1234_5678; lsu_req_wstrb = 4'hF;
    mem_req_ready = 1'b1; ifu_rsp_ready = 1'b1; lsu_rsp_ready = 1'b1;
    push(1'b0, ia, 1'b0, 32'd0, 4'd0, ird, 1'b0);
    push(1'b1, la, 1'b0, 32'h1234_5678, 4'hF, lrd, 1'b0);
    chk_req();
    tick();
    ifu_req_valid = 1'b0;
    rsp_beat();
    tick();
    mem_rsp_valid = 1'b0;
    chk_req();
    tick();
    lsu_req_valid = 1'b0;
    rsp_beat();
    tick();
    mem_rsp_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    do_reset();

    // IFU only.
    tick();
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000;
    mem_req_ready = 1'b1; ifu_rsp_ready = 1'b1;
    push(1'b0, 32'h8000_0000, 1'b0, 32'd0, 4'd0, 32'h0000_0413, 1'b0);
    chk_req();
    tick();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b0;
    rsp_beat();
    tick();
    mem_rsp_valid = 1'b0;
    #1 chk_quiet("idle_after_ifu");

    // Conflicts after reset: IFU, LSU, then IFU again.
    do_reset();
    conflict_pair(32'h8000_0000, 32'h8000_1000, 32'h1111_0001, 32'h2222_0002);
    conflict_pair(32'h8000_0010, 32'h8000_1010, 32'h1111_0003, 32'h2222_0004);

    // HOLD freeze: LSU stalled for three cycles, IFU shows up at cycle 1.
    tick();
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_2000; lsu_req_write = 1'b0;
    lsu_req_wdata = 32'd0; lsu_req_wstrb = 4'hF; mem_req_ready = 1'b0;
    push(1'b1, 32'h8000_2000, 1'b0, 32'd0, 4'hF, 32'h3333_0005, 1'b0);
    chk_req();
    tick();
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000;
    push(1'b0, 32'h8000_0000, 1'b0, 32'd0, 4'd0, 32'h4444_0006, 1'b0);
    chk_req();
    tick();
    chk_req();
    tick();
    mem_req_ready = 1'b1;
    chk_req();
    tick();
    lsu_req_valid = 1'b0;
    rsp_beat();
    tick();
    mem_rsp_valid = 1'b0;
    chk_req();
    tick();
    ifu_req_valid = 1'b0;
    rsp_beat();
    tick();
    mem_rsp_valid = 1'b0;

    // Store with response back-pressure and a bus error.
    tick();
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_3000; lsu_req_write = 1'b1;
    lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wstrb = 4'b0011; mem_req_ready = 1'b1;
    lsu_rsp_ready = 1'b0;
    push(1'b1, 32'h8000_3000, 1'b1, 32'hDEAD_BEEF, 4'b0011, 32'd0, 1'b1);
    chk_req();
    for (int i = 0; i < 2; i++) begin
      tick();
      lsu_req_valid = 1'b0;
      rsp_beat();
    end
    check_eq("store_pending", exp_q.size(), 1);
    tick();
    lsu_rsp_ready = 1'b1;
    rsp_beat();
    check_eq("store_popped", exp_q.size(), 0);
    tick();
    mem_rsp_valid = 1'b0; lsu_req_write = 1'b0;
    #1 chk_quiet("idle_after_store");

    // Reset while a fetch is outstanding; the response is then dropped.
    tick();
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_4000; mem_req_ready = 1'b1;
    ifu_rsp_ready = 1'b1;
    push(1'b0, 32'h8000_4000, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0);
    chk_req();
    tick();
    ifu_req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0BAD_0BAD; lsu_rsp_ready = 1'b1;
    #1 chk_quiet("stray_rsp");
    tick();
    #1 chk_quiet("stray_rsp2");
    mem_rsp_valid = 1'b0;
    conflict_pair(32'h8000_5000, 32'h8000_6000, 32'h5555_0007, 32'h6666_0008);

    check_eq("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
